// File: rtl/sdram_responder.sv
// Chip-side model of an SDR SDRAM (MT48LC16M16 style) used in place of the real
// device so an SDRAM controller can be exercised end to end.
//
// Ports:
//   clk, reset          - clock (pins sampled on rising edge), async active-high reset
//   sd_ncs..sd_nwe      - command strobes {ncs,nras,ncas,nwe}
//   sd_a, sd_ba         - multiplexed address and bank address
//   sd_dqml, sd_dqmh    - byte lane masks (write enable / read blanking)
//   sd_dq_in            - write data from controller
//   sd_dq_out, sd_dq_oe - read data and its valid/drive strobe
//   mode_valid, cas_lat - mode register status and latched CAS latency
//   refresh_count       - count of accepted AUTO_REFRESH commands
//   err, err_code       - sticky protocol-violation flag and code of the first violation
module sdram_responder #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned TRCD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [12:0] sd_a,
  input  logic [1:0]  sd_ba,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        mode_valid,
  output logic [1:0]  cas_lat,
  output logic [15:0] refresh_count,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [3:0] CmdLoadMode  = 4'b0000;
  localparam logic [3:0] CmdRefresh   = 4'b0001;
  localparam logic [3:0] CmdPrecharge = 4'b0010;
  localparam logic [3:0] CmdActive    = 4'b0011;
  localparam logic [3:0] CmdWrite     = 4'b0100;
  localparam logic [3:0] CmdRead      = 4'b0101;

  localparam int unsigned AgeW = (TRCD < 2) ? 1 : $clog2(TRCD + 1);

  // Per-bank state
  logic [3:0]      r_bank_act;
  logic [3:0]      r_bank_ap;   // auto-precharge due on the next edge
  logic [12:0]     r_row [4];
  logic [AgeW-1:0] r_age [4];

  logic        r_mode_valid;
  logic [1:0]  r_cas_lat;
  logic [15:0] r_refresh;
  logic        r_err;
  logic [2:0]  r_err_code;

  // Read pipeline: stage 2 feeds stage 1 feeds the output register
  logic        r_p2_vld, r_p1_vld, r_oe;
  logic [15:0] r_p2_dat, r_p1_dat, r_dq_out;

  logic [15:0] r_mem [2**ADDR_W];

  logic [3:0]        w_cmd;
  logic              w_all_idle;
  logic              w_viol;
  logic [2:0]        w_code;
  logic              w_mode_ld, w_act, w_rd, w_wr, w_ref, w_pre;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_mem_rd;
  logic [15:0]       w_rd_dat;

  assign w_cmd      = {sd_ncs, sd_nras, sd_ncas, sd_nwe};
  assign w_all_idle = ~|r_bank_act;
  assign w_addr     = ADDR_W'({sd_ba, r_row[sd_ba], sd_a[8:0]});
  assign w_mem_rd   = r_mem[w_addr];
  assign w_rd_dat   = {sd_dqmh ? 8'h00 : w_mem_rd[15:8], sd_dqml ? 8'h00 : w_mem_rd[7:0]};

  always_comb begin
    w_viol    = 1'b0;
    w_code    = 3'd0;
    w_mode_ld = 1'b0;
    w_act     = 1'b0;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_ref     = 1'b0;
    w_pre     = 1'b0;
    case (w_cmd)
      CmdLoadMode: begin
        if (!w_all_idle) begin
          w_viol = 1'b1;
          w_code = 3'd4;
        end else if (sd_a[2:0] != 3'b000 || (sd_a[6:4] != 3'd2 && sd_a[6:4] != 3'd3)) begin
          w_viol = 1'b1;
          w_code = 3'd6;
        end else begin
          w_mode_ld = 1'b1;
        end
      end
      CmdRefresh: begin
        if (!w_all_idle) begin
          w_viol = 1'b1;
          w_code = 3'd4;
        end else begin
          w_ref = 1'b1;
        end
      end
      CmdActive: begin
        if (r_bank_act[sd_ba]) begin
          w_viol = 1'b1;
          w_code = 3'd1;
        end else begin
          w_act = 1'b1;
        end
      end
      CmdRead, CmdWrite: begin
        if (!r_mode_valid) begin
          w_viol = 1'b1;
          w_code = 3'd5;
        end else if (!r_bank_act[sd_ba]) begin
          w_viol = 1'b1;
          w_code = 3'd2;
        // Stored age lags the current edge by one, hence the +1
        end else if ((32'(r_age[sd_ba]) + 32'd1) < TRCD) begin
          w_viol = 1'b1;
          w_code = 3'd3;
        end else begin
          w_rd = (w_cmd == CmdRead);
          w_wr = (w_cmd == CmdWrite);
        end
      end
      CmdPrecharge: w_pre = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_act <= '0;
      r_bank_ap  <= '0;
      for (int b = 0; b < 4; b++) begin
        r_row[b] <= '0;
        r_age[b] <= '0;
      end
    end else begin
      r_bank_ap <= '0;
      for (int b = 0; b < 4; b++) begin
        if (r_bank_act[b] && r_age[b] != AgeW'(TRCD)) r_age[b] <= r_age[b] + AgeW'(1);
        if (r_bank_ap[b]) r_bank_act[b] <= 1'b0;
      end
      if (w_act) begin
        r_bank_act[sd_ba] <= 1'b1;
        r_row[sd_ba]      <= sd_a;
        r_age[sd_ba]      <= '0;
      end
      if ((w_rd || w_wr) && sd_a[10]) r_bank_ap[sd_ba] <= 1'b1;
      if (w_pre) begin
        if (sd_a[10]) r_bank_act <= '0;
        else          r_bank_act[sd_ba] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_valid <= 1'b0;
      r_cas_lat    <= 2'd0;
      r_refresh    <= 16'd0;
      r_err        <= 1'b0;
      r_err_code   <= 3'd0;
    end else begin
      if (w_mode_ld) begin
        r_mode_valid <= 1'b1;
        r_cas_lat    <= sd_a[5:4];
      end
      if (w_ref) r_refresh <= r_refresh + 16'd1;
      if (w_viol && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  // A read enters the stage that gives it its own CAS latency, so a later mode
  // change never retimes reads already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p2_vld <= 1'b0;
      r_p2_dat <= 16'd0;
      r_p1_vld <= 1'b0;
      r_p1_dat <= 16'd0;
      r_oe     <= 1'b0;
      r_dq_out <= 16'd0;
    end else begin
      r_p2_vld <= w_rd && (r_cas_lat == 2'd3);
      r_p2_dat <= w_rd_dat;
      if (w_rd && r_cas_lat == 2'd2) begin
        r_p1_vld <= 1'b1;
        r_p1_dat <= w_rd_dat;
      end else begin
        r_p1_vld <= r_p2_vld;
        r_p1_dat <= r_p2_dat;
      end
      r_oe     <= r_p1_vld;
      r_dq_out <= r_p1_vld ? r_p1_dat : 16'd0;
    end
  end

  // Backing store is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (!sd_dqml) r_mem[w_addr][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqmh) r_mem[w_addr][15:8] <= sd_dq_in[15:8];
    end
  end

  assign sd_dq_out     = r_dq_out;
  assign sd_dq_oe      = r_oe;
  assign mode_valid    = r_mode_valid;
  assign cas_lat       = r_cas_lat;
  assign refresh_count = r_refresh;
  assign err           = r_err;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, masked writes/reads, tRCD error,
// CL2/CL3 latency, pipelined reads, reset mid-read and mode-register checks.
module tb_sdram_responder;

  logic        clk;
  logic        reset;
  logic        sd_ncs, sd_nras, sd_ncas, sd_nwe;
  logic [12:0] sd_a;
  logic [1:0]  sd_ba;
  logic        sd_dqml, sd_dqmh;
  logic [15:0] sd_dq_in;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic        mode_valid;
  logic [1:0]  cas_lat;
  logic [15:0] refresh_count;
  logic        err;
  logic [2:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] LMR = 4'b0000, REF = 4'b0001, PRE = 4'b0010, ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100, RD  = 4'b0101, NOP = 4'b0111;

  sdram_responder #(.ADDR_W(14), .TRCD(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sd_ncs       (sd_ncs),
    .sd_nras      (sd_nras),
    .sd_ncas      (sd_ncas),
    .sd_nwe       (sd_nwe),
    .sd_a         (sd_a),
    .sd_ba        (sd_ba),
    .sd_dqml      (sd_dqml),
    .sd_dqmh      (sd_dqmh),
    .sd_dq_in     (sd_dq_in),
    .sd_dq_out    (sd_dq_out),
    .sd_dq_oe     (sd_dq_oe),
    .mode_valid   (mode_valid),
    .cas_lat      (cas_lat),
    .refresh_count(refresh_count),
    .err          (err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one command, clock it in, return 1 time unit after the edge with NOP driven
  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] dq, input logic [1:0] dqm);
    {sd_ncs, sd_nras, sd_ncas, sd_nwe} = c;
    sd_ba    = ba;
    sd_a     = a;
    sd_dq_in = dq;
    {sd_dqmh, sd_dqml} = dqm;
    @(posedge clk);
    #1;
    {sd_ncs, sd_nras, sd_ncas, sd_nwe} = NOP;
    {sd_dqmh, sd_dqml} = 2'b00;
  endtask

  task automatic nop();
    drive(NOP, 2'd0, 13'h0, 16'h0, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    {sd_ncs, sd_nras, sd_ncas, sd_nwe} = 4'b1111;
    sd_a = '0; sd_ba = '0; sd_dqml = 1'b0; sd_dqmh = 1'b0; sd_dq_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe", 16'(sd_dq_oe), 16'h0);
    chk("rst_dq", sd_dq_out, 16'h0);
    chk("rst_mode_valid", 16'(mode_valid), 16'h0);
    chk("rst_cas", 16'(cas_lat), 16'h0);
    chk("rst_refresh", refresh_count, 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    reset = 1'b0;

    // Init sequence, CL2
    drive(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    drive(REF, 2'd0, 13'h000, 16'h0, 2'b00);
    drive(REF, 2'd0, 13'h000, 16'h0, 2'b00);
    drive(LMR, 2'd0, 13'h220, 16'h0, 2'b00);
    chk("init_mode_valid", 16'(mode_valid), 16'h1);
    chk("init_cas", 16'(cas_lat), 16'h2);
    chk("init_refresh", refresh_count, 16'h2);
    chk("init_err", 16'(err), 16'h0);

    // Write with auto-precharge, re-open, read back
    drive(ACT, 2'd1, 13'h0123, 16'h0, 2'b00);
    nop();
    drive(WR, 2'd1, 13'h405, 16'hBEEF, 2'b00);
    nop();
    drive(ACT, 2'd1, 13'h0123, 16'h0, 2'b00);
    nop();
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b00);
    chk("cl2_oe_at_k", 16'(sd_dq_oe), 16'h0);
    nop();
    chk("cl2_oe_at_k1", 16'(sd_dq_oe), 16'h1);
    chk("cl2_dq_at_k1", sd_dq_out, 16'hBEEF);
    nop();
    chk("cl2_oe_at_k2", 16'(sd_dq_oe), 16'h0);
    chk("cl2_dq_idle", sd_dq_out, 16'h0);
    chk("ap_no_err", 16'(err), 16'h0);

    // Byte-masked write then masked read
    drive(WR, 2'd1, 13'h005, 16'h1234, 2'b10);
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b00);
    nop();
    chk("mask_wr_dq", sd_dq_out, 16'hBE34);
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b01);
    nop();
    chk("mask_rd_dq", sd_dq_out, 16'hBE00);
    chk("mask_rd_oe", 16'(sd_dq_oe), 16'h1);

    // tRCD violation
    drive(ACT, 2'd2, 13'h0010, 16'h0, 2'b00);
    drive(RD, 2'd2, 13'h000, 16'h0, 2'b00);
    chk("trcd_err", 16'(err), 16'h1);
    chk("trcd_code", 16'(err_code), 16'h3);
    nop();
    chk("trcd_no_oe1", 16'(sd_dq_oe), 16'h0);
    nop();
    chk("trcd_no_oe2", 16'(sd_dq_oe), 16'h0);
    drive(ACT, 2'd2, 13'h0010, 16'h0, 2'b00);
    chk("sticky_code", 16'(err_code), 16'h3);

    // CL3 with back-to-back reads
    drive(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    drive(LMR, 2'd0, 13'h230, 16'h0, 2'b00);
    chk("cl3_cas", 16'(cas_lat), 16'h3);
    drive(ACT, 2'd1, 13'h0123, 16'h0, 2'b00);
    nop();
    drive(WR, 2'd1, 13'h006, 16'h5A5A, 2'b00);
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b00);
    chk("cl3_oe_k", 16'(sd_dq_oe), 16'h0);
    drive(RD, 2'd1, 13'h406, 16'h0, 2'b00);
    chk("cl3_oe_k1", 16'(sd_dq_oe), 16'h0);
    nop();
    chk("cl3_oe_k2", 16'(sd_dq_oe), 16'h1);
    chk("cl3_dq_k2", sd_dq_out, 16'hBE34);
    nop();
    chk("cl3_oe_k3", 16'(sd_dq_oe), 16'h1);
    chk("cl3_dq_k3", sd_dq_out, 16'h5A5A);
    nop();
    chk("cl3_oe_k4", 16'(sd_dq_oe), 16'h0);

    // Reset while a CL3 read is in flight
    drive(ACT, 2'd1, 13'h0123, 16'h0, 2'b00);
    nop();
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b00);
    nop();
    reset = 1'b1;
    #1;
    chk("rrst_oe", 16'(sd_dq_oe), 16'h0);
    chk("rrst_mode_valid", 16'(mode_valid), 16'h0);
    chk("rrst_cas", 16'(cas_lat), 16'h0);
    chk("rrst_err", 16'(err), 16'h0);
    chk("rrst_code", 16'(err_code), 16'h0);
    @(posedge clk);
    #1;
    chk("rrst_oe_hold", 16'(sd_dq_oe), 16'h0);
    reset = 1'b0;
    nop();
    chk("rrst_oe_after", 16'(sd_dq_oe), 16'h0);

    // Re-init without precharge: banks must already be idle
    drive(LMR, 2'd0, 13'h220, 16'h0, 2'b00);
    chk("reinit_mode_valid", 16'(mode_valid), 16'h1);
    drive(ACT, 2'd1, 13'h0123, 16'h0, 2'b00);
    chk("reinit_err", 16'(err), 16'h0);
    nop();
    drive(RD, 2'd1, 13'h005, 16'h0, 2'b00);
    nop();
    chk("retained_dq", sd_dq_out, 16'hBE34);

    // Illegal mode word: rejected, CAS unchanged
    drive(PRE, 2'd0, 13'h400, 16'h0, 2'b00);
    drive(LMR, 2'd0, 13'h250, 16'h0, 2'b00);
    chk("badmode_err", 16'(err), 16'h1);
    chk("badmode_code", 16'(err_code), 16'h6);
    chk("badmode_cas", 16'(cas_lat), 16'h2);

    // Refresh with an open bank is not counted
    drive(ACT, 2'd0, 13'h0001, 16'h0, 2'b00);
    drive(REF, 2'd0, 13'h000, 16'h0, 2'b00);
    chk("ref_busy_count", refresh_count, 16'h0);
    drive(PRE, 2'd0, 13'h000, 16'h0, 2'b00);
    drive(REF, 2'd0, 13'h000, 16'h0, 2'b00);
    chk("ref_ok_count", refresh_count, 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
